alu_muldiv_seq: RTL and testbench

- Multi-cycle unsigned multiply/divide sequencer that time-shares the core's 32-bit ALU.
- Runs shift-add multiplication (MUL, low word) or restoring division (DIVU/REMU), one ALU add or sub per iteration.
- Sits beside the ALU. While busy, the core's operand mux selects this block's ALU drive (alu_req).
- Handshake: start, then a one-cycle done pulse.

---
 rtl/alu_muldiv_seq_if.sv | 28 ++
 rtl/alu_muldiv_seq.sv | 143 ++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Request/response and ALU-sharing signals between the core and alu_muldiv_seq.
interface alu_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            alu_req;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_cf;

  modport slave (
    input  start, op, opa, opb, alu_result, alu_cf,
    output busy, done, result, alu_req, alu_ctrl, alu_a, alu_b
  );

  modport master (
    output start, op, opa, opb, alu_result, alu_cf,
    input  busy, done, result, alu_req, alu_ctrl, alu_a, alu_b
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Sequential MUL / DIVU / REMU that borrows the core ALU for one add/sub per cycle.
// Define ALU_MULDIV_SEQ_EARLY_EXIT_EN to stop MUL once the remaining multiplier is zero.
module alu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_muldiv_seq_if.slave   bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mc;
  logic [XLEN-1:0] r_mp;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_result;

  logic            w_mul;
  logic            w_resv;
  logic            w_last;
  logic            w_sub_ok;
  logic [XLEN-1:0] w_s;
  logic [XLEN-1:0] w_acc_next;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_q_next;

  assign w_mul  = (r_op == 2'b00);
  assign w_resv = (r_op == 2'b11);

  // A set remainder msb means the shifted value exceeds XLEN bits, so the subtract always fits.
  assign w_s        = {r_rem[XLEN-2:0], r_q[XLEN-1]};
  assign w_sub_ok   = r_rem[XLEN-1] | ~bus.alu_cf;
  assign w_rem_next = w_sub_ok ? bus.alu_result : w_s;
  assign w_q_next   = {r_q[XLEN-2:0], w_sub_ok};
  assign w_acc_next = r_mp[0] ? bus.alu_result : r_acc;

`ifdef ALU_MULDIV_SEQ_EARLY_EXIT_EN
  assign w_last = (r_cnt == CW'(XLEN-1)) || (w_mul && (r_mp[XLEN-1:1] == '0));
`else
  assign w_last = (r_cnt == CW'(XLEN-1));
`endif

  assign bus.result = r_result;

  always_comb begin
    w_state_next = r_state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.alu_req  = 1'b0;
    bus.alu_ctrl = 3'b000;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_RUN;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (!w_resv) begin
          bus.alu_req = 1'b1;
          if (w_mul) begin
            bus.alu_a = r_acc;
            bus.alu_b = r_mc;
          end else begin
            bus.alu_ctrl = 3'b010;
            bus.alu_a    = w_s;
            bus.alu_b    = r_dvs;
          end
        end
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        bus.done     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mc     <= '0;
      r_mp     <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_dvs    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op  <= bus.op;
            // Reserved op spends a single idle RUN cycle without touching the ALU.
            r_cnt <= (bus.op == 2'b11) ? CW'(XLEN-1) : '0;
            r_acc <= '0;
            r_mc  <= bus.opa;
            r_mp  <= bus.opb;
            r_rem <= '0;
            r_q   <= bus.opa;
            r_dvs <= bus.opb;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_mul) begin
            r_acc <= w_acc_next;
            r_mc  <= r_mc << 1;
            r_mp  <= r_mp >> 1;
          end else if (!w_resv) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
          end
          if (w_last) begin
            case (r_op)
              2'b00:   r_result <= w_acc_next;
              2'b01:   r_result <= w_q_next;
              2'b10:   r_result <= w_rem_next;
              default: r_result <= '0;
            endcase
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq with an in-bench ALU and arithmetic reference model.
module tb_alu_muldiv_seq;
  localparam int XLEN = 32;
`ifdef ALU_MULDIV_SEQ_EARLY_EXIT_EN
  localparam int MUL76_LAT = 3;
`else
  localparam int MUL76_LAT = 32;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mon_en = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.XLEN(XLEN)) bus ();

  alu_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core ALU stand-in: 33-bit add/sub, bit 32 is carry/borrow.
  logic [XLEN:0] alu_full;
  assign alu_full = (bus.alu_ctrl == 3'b010) ? ({1'b0, bus.alu_a} - {1'b0, bus.alu_b})
                                             : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
  assign bus.alu_result = alu_full[XLEN-1:0];
  assign bus.alu_cf     = alu_full[XLEN];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [XLEN-1:0] p;
    case (op)
      2'd0: begin p = a * b; return p; end
      2'd1: return (b == 0) ? '1 : a / b;
      2'd2: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [XLEN-1:0] b);
    if (op == 2'd3) return 1;
`ifdef ALU_MULDIV_SEQ_EARLY_EXIT_EN
    if (op == 2'd0) begin
      int n = 1;
      for (int i = 0; i < XLEN; i++) if (b[i]) n = i + 1;
      return n;
    end
`endif
    return XLEN;
  endfunction

  // Partial product after k multiplier bits have been consumed.
  function automatic logic [XLEN-1:0] ref_mul_acc(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                  input int k);
    logic [63:0] mask, p;
    mask = (64'd1 << k) - 64'd1;
    p    = {32'd0, a} * ({32'd0, b} & mask);
    return p[XLEN-1:0];
  endfunction

  // Trial dividend of iteration k: (top k dividend bits mod divisor) * 2 + next dividend bit.
  function automatic logic [XLEN-1:0] ref_div_s(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                input int k);
    logic [63:0] top, rem, s;
    top = (k == 0) ? 64'd0 : ({32'd0, a} >> (XLEN - k));
    rem = (b == 0) ? top : top % {32'd0, b};
    s   = (rem << 1) | {63'd0, a[XLEN-1-k]};
    return s[XLEN-1:0];
  endfunction

  // Reference model: transaction accepted when idle, busy for lat cycles, then one done cycle.
  logic            m_active = 1'b0;
  int              m_k      = 0;
  int              m_lat    = 0;
  logic [1:0]      m_op     = 2'd0;
  logic [XLEN-1:0] m_a      = '0;
  logic [XLEN-1:0] m_b      = '0;
  logic [XLEN-1:0] m_exp    = '0;
  logic [XLEN-1:0] m_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_result <= '0;
    end else if (m_active) begin
      if (m_k == m_lat) m_active <= 1'b0;
      else begin
        m_k <= m_k + 1;
        if (m_k + 1 == m_lat) m_result <= m_exp;
      end
    end else if (bus.start === 1'b1) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_op     <= bus.op;
      m_a      <= bus.opa;
      m_b      <= bus.opb;
      m_lat    <= ref_latency(bus.op, bus.opb);
      m_exp    <= ref_result(bus.op, bus.opa, bus.opb);
    end
  end

  logic e_busy, e_done, e_req;
  assign e_busy = m_active && (m_k < m_lat);
  assign e_done = m_active && (m_k == m_lat);
  assign e_req  = e_busy && (m_op != 2'd3);

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
      chk("done", {31'd0, bus.done}, {31'd0, e_done});
      chk("alu_req", {31'd0, bus.alu_req}, {31'd0, e_req});
      chk("result", bus.result, m_result);
      if (!e_req) begin
        chk("idle_alu_ctrl", {29'd0, bus.alu_ctrl}, '0);
        chk("idle_alu_a", bus.alu_a, '0);
        chk("idle_alu_b", bus.alu_b, '0);
      end else if (m_op == 2'd0) begin
        chk("mul_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd0);
        chk("mul_alu_a", bus.alu_a, ref_mul_acc(m_a, m_b, m_k));
        chk("mul_alu_b", bus.alu_b, m_a << m_k);
      end else begin
        chk("div_alu_ctrl", {29'd0, bus.alu_ctrl}, 32'd2);
        chk("div_alu_a", bus.alu_a, ref_div_s(m_a, m_b, m_k));
        chk("div_alu_b", bus.alu_b, m_b);
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input bit hold, input bit pin, input logic [XLEN-1:0] lit_res, input int lit_lat);
    int  cyc;
    bit  seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!hold) bus.start = 1'b0;
      bus.op  = 2'($urandom);
      bus.opa = $urandom;
      bus.opb = $urandom;
      if (bus.done === 1'b1) seen = 1;
    end
    bus.start = 1'b0;
    chk("done_timeout", {31'd0, seen}, 32'd1);
    if (pin) begin
      chk("lit_result", bus.result, lit_res);
      chk("lit_latency", 32'(cyc - 1), 32'(lit_lat));
    end
    $display("op=%0d a=%h b=%h hold=%0d result=%h latency=%0d", op, a, b, hold, bus.result, cyc - 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.opa   = '0;
    bus.opb   = '0;
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'd0, 32'd7, 32'd6, 1'b1, 1'b1, 32'd42, MUL76_LAT);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0001, 32);
    run_op(2'd1, 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32);
    run_op(2'd2, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32);
    run_op(2'd1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1, 32'd1, 32);
    run_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 1'b1, 32'h7FFF_FFFE, 32);
    run_op(2'd1, 32'd1234, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32);
    run_op(2'd2, 32'd1234, 32'd0, 1'b0, 1'b1, 32'd1234, 32);
    run_op(2'd3, 32'd55, 32'd66, 1'b0, 1'b1, 32'd0, 1);

    for (int t = 0; t < 40; t++) begin
      logic [1:0]      rop;
      logic [XLEN-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, ($urandom_range(0, 3) == 0), 1'b0, '0, 0);
    end

    // Abort a MUL with an asynchronous reset partway through.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.opa   = 32'd123;
    bus.opb   = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_alu_req", {31'd0, bus.alu_req}, 32'd0);
    $display("reset abort: busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run_op(2'd1, 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
